// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared types and constants for the ALU arbiter slice.
//   arb_state_t   : arbiter FSM states (IDLE, EXEC, RESP)
//   ALU_DATA_W    : default operand/result width
//   ALU_SEL_W     : default opcode width
//   OP_*          : named ALU opcodes, used by benches and drivers
package alu_arbiter_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [ALU_SEL_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] OP_MUL  = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] OP_DIV  = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] OP_SHL  = 4'b0100;
  localparam logic [ALU_SEL_W-1:0] OP_SHR  = 4'b0101;
  localparam logic [ALU_SEL_W-1:0] OP_ROL  = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] OP_ROR  = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] OP_AND  = 4'b1000;
  localparam logic [ALU_SEL_W-1:0] OP_OR   = 4'b1001;
  localparam logic [ALU_SEL_W-1:0] OP_XOR  = 4'b1010;
  localparam logic [ALU_SEL_W-1:0] OP_NOR  = 4'b1011;
  localparam logic [ALU_SEL_W-1:0] OP_NAND = 4'b1100;
  localparam logic [ALU_SEL_W-1:0] OP_XNOR = 4'b1101;
  localparam logic [ALU_SEL_W-1:0] OP_GT   = 4'b1110;
  localparam logic [ALU_SEL_W-1:0] OP_EQ   = 4'b1111;

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter
// Purely combinational N-way round-robin pick.
//   req   : request vector
//   ptr   : index of the last winner; search starts at ptr+1 and wraps
//   grant : one-hot winner (zero when no request)
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Index ptr+k folded back into 0..N-1 (works for non-power-of-two N).
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int c;
    c = int'(p) + k;
    if (c >= N) c = c - N;
    return IW'(c);
  endfunction

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Walk from the farthest candidate to the nearest so the closest
    // requester after ptr is the last (winning) write.
    for (int k = N; k >= 1; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        idx = wrap_idx(ptr, k);
        any = 1'b1;
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU among N_REQ requesters. A round-robin pick
// in IDLE registers the winner's operands onto the ALU, one EXEC cycle lets
// the ALU settle, and the captured result is held in RESP until the owner
// accepts it.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake (req_ready one-hot)
//   req_a/req_b/req_sel           : packed per-requester operands/opcode
//   rsp_valid/rsp_ready/rsp_data  : response handshake, shared data bus
//   alu_a/alu_b/alu_sel/alu_out   : connection to the external ALU
//   busy                          : FSM not in IDLE
//   op_count                      : per-requester completed-op counters,
//                                   present only with ALU_ARBITER_STATS_EN
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int N_REQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*SEL_W-1:0]  req_sel,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [SEL_W-1:0]        alu_sel,
  input  logic [DATA_W-1:0]       alu_out,
  output logic                    busy
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     op_count
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);

  arb_state_t        state_reg, state_next;
  logic [IW-1:0]     ptr_reg, owner_reg;
  logic [DATA_W-1:0] alu_a_reg, alu_b_reg, rsp_data_reg;
  logic [SEL_W-1:0]  alu_sel_reg;

  logic [DATA_W-1:0] a_arr   [N_REQ];
  logic [DATA_W-1:0] b_arr   [N_REQ];
  logic [SEL_W-1:0]  sel_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
    assign sel_arr[gi] = req_sel[gi*SEL_W +: SEL_W];
  end

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  logic accept, rsp_fire;

  // Handshake outputs are masked during reset so no grant or response is
  // ever offered in a cycle whose edge discards it.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    rsp_valid  = '0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_any && !rst) begin
          req_ready  = pick_grant;
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (!rst) begin
          rsp_valid = N_REQ'(1) << owner_reg;
          if (rsp_ready[owner_reg]) begin
            rsp_fire   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= PTR_RST;
      owner_reg    <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_sel_reg  <= '0;
      rsp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_a_reg   <= a_arr[pick_idx];
        alu_b_reg   <= b_arr[pick_idx];
        alu_sel_reg <= sel_arr[pick_idx];
        owner_reg   <= pick_idx;
        ptr_reg     <= pick_idx;
      end
      // ALU inputs have been stable for a full cycle by the end of EXEC.
      if (state_reg == EXEC) rsp_data_reg <= alu_out;
    end
  end

  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign alu_sel  = alu_sel_reg;
  assign rsp_data = rsp_data_reg;
  assign busy     = (state_reg != IDLE);

`ifdef ALU_ARBITER_STATS_EN
  logic [N_REQ*16-1:0] op_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (rsp_fire) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i] && (op_count_reg[i*16 +: 16] != 16'hFFFF))
          op_count_reg[i*16 +: 16] <= op_count_reg[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*SW-1:0] req_sel;
  logic [DW-1:0]   rsp_data, alu_a, alu_b, alu_out;
  logic [SW-1:0]   alu_sel;
  logic            busy;
`ifdef ALU_ARBITER_STATS_EN
  logic [N*16-1:0] op_count;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .SEL_W(SW), .N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .busy(busy)
`ifdef ALU_ARBITER_STATS_EN
    , .op_count(op_count)
`endif
  );

  // Behavioural ALU standing in for the shared instance.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      OP_ADD: alu_out = alu_a + alu_b;
      OP_SUB: alu_out = alu_a - alu_b;
      OP_MUL: alu_out = alu_a * alu_b;
      OP_SHL: alu_out = alu_a << 1;
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      OP_GT:  alu_out = (alu_a > alu_b) ? 8'd1 : 8'd0;
      OP_EQ:  alu_out = (alu_a == alu_b) ? 8'd1 : 8'd0;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    int            idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [SW-1:0] sel;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   rsp_count = 0;
  int   cyc = 0;
  int   grant_cyc = 0;
  int   last_grant = 0;
  logic [N-1:0] prev_rsp_valid = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor and scoreboard pop.
  always @(negedge clk) begin
    if (rst) begin
      prev_rsp_valid = '0;
    end else begin
      exp_t e;
      if (req_ready != '0) begin
        chk("ready_onehot", 64'($onehot(req_ready)), 64'(1));
        last_grant = oh2idx(req_ready);
        grant_cyc  = cyc;
      end
      if (rsp_valid != '0 && prev_rsp_valid == '0) begin
        chk("rsp_latency", 64'(cyc - grant_cyc), 64'(2));
        chk("rsp_owner", 64'(rsp_valid), 64'(1) << last_grant);
      end
      if ((rsp_valid & rsp_ready) != '0) begin
        chk("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rsp_idx", 64'(rsp_valid), 64'(1) << e.idx);
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          $display("rsp req%0d data=%0d (expected req%0d data=%0d)",
                   oh2idx(rsp_valid), rsp_data, e.idx, e.data);
        end
        rsp_count++;
      end
      prev_rsp_valid = rsp_valid;
    end
  end

  task automatic wait_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [SW-1:0] sel);
    req_a[idx*DW +: DW]   = a;
    req_b[idx*DW +: DW]   = b;
    req_sel[idx*SW +: SW] = sel;
  endtask

  task automatic push(input int idx, input logic [DW-1:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    #1;
    while (req_ready[idx] !== 1'b1 && n < 20) begin
      wait_cyc();
      n++;
    end
    chk("grant", 64'(req_ready), 64'(1) << idx);
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 60) begin
      wait_cyc();
      n++;
    end
    chk("rsp_count", 64'(rsp_count), 64'(target));
  endtask

  task automatic single_op(input vec_t v);
    int base = rsp_count;
    set_req(v.idx, v.a, v.b, v.sel);
    req_valid[v.idx] = 1'b1;
    push(v.idx, v.exp);
    wait_ready(v.idx);
    wait_cyc();
    req_valid[v.idx] = 1'b0;
    chk("alu_a", 64'(alu_a), 64'(v.a));
    chk("alu_b", 64'(alu_b), 64'(v.b));
    chk("alu_sel", 64'(alu_sel), 64'(v.sel));
    chk("busy_exec", 64'(busy), 64'(1));
    chk("no_ready_exec", 64'(req_ready), 64'(0));
    wait_rsp(base + 1);
    chk("busy_after", 64'(busy), 64'(0));
    chk("alu_a_hold", 64'(alu_a), 64'(v.a));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc();
    wait_cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic [DW-1:0] fa[4];
    logic [DW-1:0] fexp[4];
    int base;

    vecs[0] = '{0, 8'd40,  8'd20,  OP_ADD, 8'd60};
    vecs[1] = '{1, 8'd40,  8'd20,  OP_SUB, 8'd20};
    vecs[2] = '{2, 8'd200, 8'd100, OP_ADD, 8'd44};
    vecs[3] = '{3, 8'h0F,  8'h3C,  OP_AND, 8'h0C};
    vecs[4] = '{0, 8'hF0,  8'h0F,  OP_OR,  8'hFF};
    vecs[5] = '{1, 8'hAA,  8'hFF,  OP_XOR, 8'h55};
    vecs[6] = '{2, 8'h81,  8'h00,  OP_SHL, 8'h02};
    vecs[7] = '{3, 8'd5,   8'd9,   OP_GT,  8'd0};
    vecs[8] = '{0, 8'd9,   8'd9,   OP_EQ,  8'd1};
    vecs[9] = '{1, 8'd12,  8'd4,   OP_MUL, 8'd48};
    fa   = '{8'd10, 8'd20, 8'd30, 8'd40};
    fexp = '{8'd12, 8'd22, 8'd32, 8'd42};

    rst = 1'b1; req_valid = '0; rsp_ready = '1;
    req_a = '0; req_b = '0; req_sel = '0;
    wait_cyc(); wait_cyc(); wait_cyc();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_alu_sel", 64'(alu_sel), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    wait_cyc();

    // Table of single operations.
    for (int i = 0; i < 10; i++) single_op(vecs[i]);

    // Contention from reset: req0 first, req1 right after its handshake.
    do_reset();
    base = rsp_count;
    set_req(0, 8'd40, 8'd20, OP_ADD);
    set_req(1, 8'd40, 8'd20, OP_SUB);
    req_valid = 4'b0011;
    push(0, 8'd60);
    push(1, 8'd20);
    wait_ready(0);
    wait_cyc();
    wait_rsp(base + 1);
    chk("contend_second", 64'(req_ready), 64'(4'b0010));
    req_valid[0] = 1'b0;
    wait_cyc();
    req_valid[1] = 1'b0;
    wait_rsp(base + 2);

    // Fairness with wrap-around: all valid for 8 grants.
    do_reset();
    base = rsp_count;
    for (int i = 0; i < N; i++) set_req(i, fa[i], 8'd2, OP_ADD);
    for (int k = 0; k < 8; k++) push(k % N, fexp[k % N]);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      wait_ready(k % N);
      wait_cyc();
      if (k == 7) req_valid = '0;
      wait_rsp(base + k + 1);
    end

    // Back-pressure; non-owner rsp_ready bits must be ignored.
    base = rsp_count;
    rsp_ready = 4'b1011;
    set_req(2, 8'd7, 8'd8, OP_ADD);
    req_valid[2] = 1'b1;
    push(2, 8'd15);
    wait_ready(2);
    wait_cyc();
    req_valid[2] = 1'b0;
    set_req(3, 8'd3, 8'd4, OP_MUL);
    req_valid[3] = 1'b1;
    push(3, 8'd12);
    for (int n = 0; n < 10 && rsp_valid == '0; n++) wait_cyc();
    for (int n = 0; n < 5; n++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
      chk("bp_rsp_data", 64'(rsp_data), 64'(15));
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_no_ready", 64'(req_ready), 64'(0));
      wait_cyc();
    end
    rsp_ready = '1;
    wait_cyc();
    chk("bp_release_idle", 64'(busy), 64'(0));
    chk("bp_next_grant", 64'(req_ready), 64'(4'b1000));
    wait_cyc();
    req_valid[3] = 1'b0;
    wait_rsp(base + 2);

    // Reset during EXEC abandons the op.
    base = rsp_count;
    set_req(1, 8'd1, 8'd1, OP_ADD);
    req_valid[1] = 1'b1;
    wait_ready(1);
    wait_cyc();
    req_valid[1] = 1'b0;
    rst = 1'b1;
    wait_cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_alu_a", 64'(alu_a), 64'(0));
    chk("mid_rst_alu_b", 64'(alu_b), 64'(0));
    chk("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    for (int n = 0; n < 3; n++) begin
      wait_cyc();
      chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    chk("mid_rst_count", 64'(rsp_count), 64'(base));
    set_req(0, 8'd6, 8'd6, OP_ADD);
    set_req(3, 8'd1, 8'd2, OP_SUB);
    req_valid = 4'b1001;
    push(0, 8'd12);
    push(3, 8'hFF);
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
    wait_cyc();
    req_valid[0] = 1'b0;
    wait_rsp(base + 1);
    chk("post_rst_second", 64'(req_ready), 64'(4'b1000));
    wait_cyc();
    req_valid[3] = 1'b0;
    wait_rsp(base + 2);

`ifdef ALU_ARBITER_STATS_EN
    for (int k = 0; k < 3; k++) single_op(vecs[1]);
    chk("stats_low", 64'(op_count[31:0]), 64'({16'd3, 16'd1}));
    chk("stats_req2", 64'(op_count[47:32]), 64'(0));
    chk("stats_req3", 64'(op_count[63:48]), 64'(1));
    force dut.op_count_reg = {op_count[63:16], 16'hFFFF};
    wait_cyc();
    release dut.op_count_reg;
    single_op(vecs[0]);
    chk("stats_saturate", 64'(op_count[15:0]), 64'(16'hFFFF));
`endif

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (ports A, B, ALU_Sel[3:0], ALU_Out) among N_REQ requesters.
- Arbitrates round-robin and registers the selected operands onto the ALU.
- Captures the ALU result and returns it to the winning requester over a valid/ready response channel.
- Sits between the requesting units (sequencers, DMA, test drivers) and the single ALU instance.

Parameters:
- DATA_W, 8, operand/result width; matches the ALU A/B/ALU_Out width.
- SEL_W, 4, ALU opcode width; matches ALU_Sel.
- N_REQ, 2, number of requesters; legal range 2..4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  one-hot grant/accept.
- req_a  in  N_REQ*DATA_W  packed operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  N_REQ*DATA_W  packed operand B.
- req_sel  in  N_REQ*SEL_W  packed opcode.
- rsp_valid  out  N_REQ  one-hot result valid.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  DATA_W  result, shared by all requesters and qualified by rsp_valid.
- alu_a  out  DATA_W  to ALU A; registered.
- alu_b  out  DATA_W  to ALU B; registered.
- alu_sel  out  SEL_W  to ALU ALU_Sel; registered.
- alu_out  in  DATA_W  from ALU ALU_Out.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high) drives all outputs to 0: state=IDLE, rr pointer=N_REQ-1 (requester 0 wins first), alu_a/alu_b/alu_sel=0, rsp_data=0, owner=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE
  - If any req_valid is set, the round-robin pick g is the first set bit searching from pointer+1 with wrap-around.
  - req_ready[g]=1 combinationally in this cycle only.
  - On the clock edge: alu_a/b/sel <= requester g's fields, owner <= g, pointer <= g, state -> EXEC.
  - If no req_valid is set, req_ready=0 and the state stays IDLE.
- EXEC: one settle cycle for the ALU. On the clock edge rsp_data <= alu_out and state -> RESP.
- RESP
  - rsp_valid[owner]=1 and rsp_data is held stable.
  - When rsp_ready[owner]=1: state -> IDLE and rsp_valid drops on the next cycle.
  - rsp_ready bits of non-owners are ignored.
- req_ready is 0 in EXEC and RESP. There is no new acceptance before the response handshake completes; back-to-back overlap is not supported.
- Latency: acceptance edge T gives rsp_valid high from T+2. Minimum issue interval is 3 cycles.
- alu_a/b/sel hold their last values outside EXEC; they change only on acceptance.
- Requester obligation: hold req_a/b/sel stable while req_valid=1 and req_ready=0. Deasserting req_valid before grant is legal; the request is withdrawn.
- Simultaneous requests: exactly one is granted per IDLE cycle. Losers keep req_ready=0. Fairness bound: a continuously valid requester is granted within N_REQ grants.
- Opcode values pass through unchanged; no width conversion or sign handling is done here. rsp_data is the ALU's DATA_W result, truncated by the ALU.
- Reset in EXEC or RESP abandons the transaction: no rsp_valid is issued, and the next cycle is IDLE with pointer=N_REQ-1.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- With the macro defined:
  - Adds output op_count (N_REQ*16), a packed per-requester count of completed responses.
  - Count increments on rsp_valid[i] & rsp_ready[i] and saturates at 16'hFFFF.
  - Cleared to 0 by rst.
- Without the macro: the port and its counters are absent, and all other behaviour is identical.

Decomposition:
- Package alu_arbiter_pkg holds:
  - the state enum {IDLE, EXEC, RESP};
  - default widths ALU_DATA_W=8 and ALU_SEL_W=4;
  - named ALU opcode constants 4'b0000..4'b1111, for benches.
- Sub-module rr_arbiter: N-way round-robin; inputs req and pointer, outputs one-hot grant and index. It is purely combinational; the pointer register lives in alu_arbiter.

Test Plan:
- Single op: req_valid=01, A=40, B=20, sel=0000 (ALU add) -> req_ready=01 at T; rsp_valid=01 at T+2; rsp_data=60; alu_a=40, alu_b=20 from T+1.
- Contention: both valid from reset, req0=(40,20,add), req1=(40,20,sub=0001) -> grant order req0 then req1; rsp_data 60 then 20; req1 granted immediately after req0's response handshake.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable, busy=1, and no req_ready pulses; release -> IDLE on the next cycle.
- Fairness and wrap-around: N_REQ=4, all valid continuously for 8 ops -> grant sequence 0,1,2,3,0,1,2,3.
- Reset mid-operation: assert rst in EXEC -> no rsp_valid appears, outputs are 0 the next cycle, and the next grant goes to requester 0.
- ALU_ARBITER_STATS_EN build: 3 ops by req1 and 1 by req0 -> op_count = {..., 16'd3, 16'd1}. Preload a counter to 16'hFFFF by force and complete one more op -> the count holds at 16'hFFFF.
